// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
//   Host-to-device transmitter for a PS/2 port. It inhibits the bus by holding
//   the clock low, issues the start bit, and shifts out eight data bits (LSB
//   first), an odd-parity bit and a stop bit on the device-generated falling
//   clock edges. It then samples the device ACK, waits for the bus to go idle
//   and reports completion. A watchdog aborts the transfer when the device
//   stops clocking.
//
// Parameters
//   INHIBIT  clock-low inhibit length, in clock cycles
//   TIMEOUT  maximum number of cycles between device falling edges (and from
//            the end of inhibit to the first edge)
//   FILTER   consecutive equal samples needed to accept a new PS/2 clock level
//
// Ports
//   clock   in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   start   in   single-cycle send request, honoured only when idle
//   data    in   command byte, latched on an accepted start
//   busy    out  transfer in progress
//   done    out  single-cycle end-of-transfer pulse
//   error   out  qualified by done: 1 = NACK or timeout
//   ps2CkI  in   PS/2 clock line level (asynchronous)
//   ps2DQI  in   PS/2 data line level (asynchronous)
//   ps2CkO  out  1 pulls the PS/2 clock line low (open drain)
//   ps2DQO  out  1 pulls the PS/2 data line low (open drain)
// -----------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT = 3200,
    parameter int TIMEOUT = 480000,
    parameter int FILTER  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2CkI,
    input  logic       ps2DQI,
    output logic       ps2CkO,
    output logic       ps2DQO
);

    localparam int CNT_MAX = (TIMEOUT > INHIBIT) ? TIMEOUT : INHIBIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_SEND,
        S_ACK,
        S_RELEASE,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;          // inhibit length, then watchdog
    logic [3:0]         bit_cnt_q, bit_cnt_d;  // falling edges seen in SEND
    logic [7:0]         data_q, data_d;
    logic               parity_q, parity_d;
    logic               nack_q, nack_d;        // also set by a timeout
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic               ck_o_q, ck_o_d;
    logic               dq_o_q, dq_o_d;

    logic               ck_meta_q, ck_meta_d;
    logic               ck_sync_q, ck_sync_d;
    logic               dq_meta_q, dq_meta_d;
    logic               dq_sync_q, dq_sync_d;
    logic               ck_filt_q, ck_filt_d;
    logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
    logic               fall;

    // Synchronizers and clock glitch filter. The filtered level only changes
    // after FILTER consecutive samples disagree with it; a falling edge is
    // reported in the same cycle the filtered level drops.
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        ck_meta_d = ps2CkI;
        ck_sync_d = ck_meta_q;
        dq_meta_d = ps2DQI;
        dq_sync_d = dq_meta_q;
        ck_filt_d = ck_filt_q;
        flt_cnt_d = '0;
        fall      = 1'b0;
        if (ck_sync_q != ck_filt_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                ck_filt_d = ck_sync_q;
                fall      = ck_filt_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // Transfer sequencing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        parity_d  = parity_q;
        nack_d    = nack_q;
        ck_o_d    = ck_o_q;
        dq_o_d    = dq_o_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d    = data;
                    parity_d  = ~^data;
                    bit_cnt_d = '0;
                    cnt_d     = '0;
                    nack_d    = 1'b0;
                    ck_o_d    = 1'b1;
                    dq_o_d    = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end

            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    // Release the clock and drive the start bit together.
                    cnt_d   = '0;
                    ck_o_d  = 1'b0;
                    dq_o_d  = 1'b1;
                    state_d = S_SEND;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_SEND, S_ACK, S_RELEASE: begin
                cnt_d = fall ? '0 : cnt_q + 1'b1;

                if (state_q == S_SEND && fall) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        dq_o_d = ~data_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        dq_o_d = ~parity_q;
                    end else begin
                        dq_o_d  = 1'b0;              // stop bit: line released
                        state_d = S_ACK;
                    end
                end else if (state_q == S_ACK && fall) begin
                    nack_d  = dq_sync_q;
                    state_d = S_RELEASE;
                end else if (state_q == S_RELEASE && dq_sync_q && ck_filt_q) begin
                    state_d = S_FINISH;
                end

                // Watchdog: the device has stopped clocking, so give up the bus.
                if (!fall && cnt_q == TO_LAST) begin
                    ck_o_d  = 1'b0;
                    dq_o_d  = 1'b0;
                    nack_d  = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FINISH);
        error_d = (state_d == S_FINISH) && nack_d;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed in the previous cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            nack_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            ck_o_q    <= 1'b0;
            dq_o_q    <= 1'b0;
            // Idle PS/2 lines are high, so the input path starts there.
            ck_meta_q <= 1'b1;
            ck_sync_q <= 1'b1;
            dq_meta_q <= 1'b1;
            dq_sync_q <= 1'b1;
            ck_filt_q <= 1'b1;
            flt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            nack_q    <= nack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            ck_o_q    <= ck_o_d;
            dq_o_q    <= dq_o_d;
            ck_meta_q <= ck_meta_d;
            ck_sync_q <= ck_sync_d;
            dq_meta_q <= dq_meta_d;
            dq_sync_q <= dq_sync_d;
            ck_filt_q <= ck_filt_d;
            flt_cnt_q <= flt_cnt_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign ps2CkO = ck_o_q;
    assign ps2DQO = dq_o_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
//   Bench for ps2_host_tx. A PS/2 device model generates the clock, samples the
//   data line on each rising clock edge and answers with ACK or NACK. A cycle
//   monitor checks busy/done/error and both line drivers on every cycle against
//   an expectation built from the accepted-start time, the inhibit length and
//   the expected error outcome; directed tests check the shifted frames.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int INHIBIT = 32;
    localparam int TIMEOUT = 2000;
    localparam int FILTER  = 8;
    localparam int HALF    = 30;   // device clock half period, in cycles

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       busy, done, error;
    logic       ps2CkO, ps2DQO;
    logic       ps2CkI, ps2DQI;
    logic       dev_ck_low = 1'b0;
    logic       dev_dq_low = 1'b0;

    // Open-drain bus with pull-ups.
    assign ps2CkI = ~(ps2CkO | dev_ck_low);
    assign ps2DQI = ~(ps2DQO | dev_dq_low);

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int done_cnt  = 0;
    int last_done = 0;
    int m_acc     = 0;     // cycle number of the clock edge that accepts start
    bit m_active  = 1'b0;
    bit m_exp_err = 1'b0;

    ps2_host_tx #(
        .INHIBIT(INHIBIT),
        .TIMEOUT(TIMEOUT),
        .FILTER (FILTER)
    ) dut (
        .clock (clk),
        .reset (reset),
        .start (start),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .error (error),
        .ps2CkI(ps2CkI),
        .ps2DQI(ps2DQI),
        .ps2CkO(ps2CkO),
        .ps2DQO(ps2DQO)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as it must appear on the data line, bit 0 first:
    // eight data bits LSB first, odd parity, stop bit.
    function automatic logic [9:0] frame_of(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

    // Per-cycle monitor.
    always @(negedge clk) begin
        bit exp_busy;
        bit in_inhibit;
        if (!reset) begin
            exp_busy   = m_active && (cyc >= m_acc);
            in_inhibit = exp_busy && (cyc < m_acc + INHIBIT);
            check("busy", 32'(busy), 32'(exp_busy));
            check("ck_o", 32'(ps2CkO), 32'(in_inhibit));
            if (in_inhibit)
                check("dq_o_inhibit", 32'(ps2DQO), 32'd0);
            if (exp_busy && cyc == m_acc + INHIBIT)
                check("start_bit", 32'(ps2DQO), 32'd1);
            if (!exp_busy) begin
                check("dq_o_idle", 32'(ps2DQO), 32'd0);
                check("done_idle", 32'(done), 32'd0);
            end
            if (done) begin
                check("error_at_done", 32'(error), 32'(m_exp_err));
                check("dq_o_at_done", 32'(ps2DQO), 32'd0);
                done_cnt++;
                last_done = cyc;
                m_active  = 1'b0;
            end else begin
                check("error_without_done", 32'(error), 32'd0);
            end
        end
    end

    // Called at a negedge; start is seen by the next rising edge.
    task automatic send_start(input logic [7:0] d, input bit exp_err);
        m_exp_err = exp_err;
        data      = d;
        start     = 1'b1;
        m_acc     = cyc + 1;
        m_active  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data  = 8'h00;
    endtask

    // Device side of one host-to-device transfer. Returns early, with the
    // clock still held low, after falling edge abort_after.
    task automatic device_xfer(input bit ack, input bit glitch, input int abort_after,
                               output logic [9:0] seen);
        int t;
        seen = '0;
        t    = 0;
        while (!(ps2CkO == 1'b0 && ps2DQO == 1'b1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("dev_sees_start_bit", 32'(t < 200), 32'd1);
        repeat (HALF) @(negedge clk);
        for (int n = 1; n <= 11; n++) begin
            if (n == 11 && ack) dev_dq_low = 1'b1;
            dev_ck_low = 1'b1;
            if (glitch) begin
                repeat (15) @(negedge clk);
                dev_ck_low = 1'b0;
                repeat (3) @(negedge clk);
                dev_ck_low = 1'b1;
                repeat (HALF - 18) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            if (n == abort_after) return;
            dev_ck_low = 1'b0;
            if (n <= 10) seen[n-1] = ps2DQI;
            dev_dq_low = 1'b0;
            if (glitch) begin
                repeat (12) @(negedge clk);
                dev_ck_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_ck_low = 1'b0;
                repeat (HALF - 15) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input int base, input string name);
        int t;
        t = 0;
        while (done_cnt == base && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check({name, "_done_count"}, 32'(done_cnt), 32'(base + 1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [9:0] seen;
        int         base;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_ck_o", 32'(ps2CkO), 32'd0);
        check("rst_dq_o", 32'(ps2DQO), 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 8'hED with ACK: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
        base = done_cnt;
        send_start(8'hED, 1'b0);
        device_xfer(1'b1, 1'b0, 0, seen);
        check("ed_frame", 32'(seen), 32'h3ED);
        wait_done(base, "ed");

        // 8'hF4 with NACK: parity 0.
        base = done_cnt;
        send_start(8'hF4, 1'b1);
        device_xfer(1'b0, 1'b0, 0, seen);
        check("f4_parity", 32'(seen[8]), 32'd0);
        check("f4_frame", 32'(seen), 32'h2F4);
        wait_done(base, "f4");

        // 8'h00, device never clocks.
        base = done_cnt;
        send_start(8'h00, 1'b1);
        wait_done(base, "timeout");
        check("timeout_latency", 32'(last_done - (m_acc + INHIBIT)), 32'd2000);

        // A second start three cycles into a transfer is ignored.
        base = done_cnt;
        send_start(8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        data  = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data  = 8'h00;
        device_xfer(1'b1, 1'b0, 0, seen);
        check("ignored_start_frame", 32'(seen), 32'(frame_of(8'h5A)));
        wait_done(base, "ignored_start");
        repeat (100) @(negedge clk);
        check("ignored_start_single_done", 32'(done_cnt), 32'(base + 1));

        // Reset after falling edge 5.
        base = done_cnt;
        send_start(8'h3C, 1'b0);
        device_xfer(1'b1, 1'b0, 5, seen);
        #2;
        reset    = 1'b1;
        m_active = 1'b0;
        #1;
        check("abort_ck_o", 32'(ps2CkO), 32'd0);
        check("abort_dq_o", 32'(ps2DQO), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        dev_ck_low = 1'b0;
        dev_dq_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Start on the very first edge after reset release.
        send_start(8'hA7, 1'b0);
        check("abort_no_done", 32'(done_cnt), 32'(base));
        check("restart_busy", 32'(busy), 32'd1);
        device_xfer(1'b1, 1'b0, 0, seen);
        check("restart_frame", 32'(seen), 32'(frame_of(8'hA7)));
        wait_done(base, "restart");

        // Short clock glitches in both halves of every bit.
        base = done_cnt;
        send_start(8'h96, 1'b0);
        device_xfer(1'b1, 1'b1, 0, seen);
        check("glitch_frame", 32'(seen), 32'(frame_of(8'h96)));
        wait_done(base, "glitch");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT, default 3200, is the clock-low inhibit length in clock cycles (100 us at 32 MHz).
REQ-002 Parameter TIMEOUT, default 480000, is the maximum number of cycles allowed between device clock falling edges, or between end of inhibit and the first edge (15 ms at 32 MHz).
REQ-003 Parameter FILTER, default 8, is the number of consecutive equal samples required to accept a new PS/2 clock level.
REQ-004 clock  in  1  system clock; all logic is on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to send `data`; sampled only in IDLE.
REQ-007 data  in  8  command byte; latched on an accepted start.
REQ-008 busy  out  1  high from the cycle after an accepted start until the cycle after done.
REQ-009 done  out  1  single-cycle pulse at the end of a transfer.
REQ-010 error  out  1  valid while done=1; 1 means NACK or timeout.
REQ-011 ps2CkI  in  1  PS/2 clock line level, asynchronous.
REQ-012 ps2DQI  in  1  PS/2 data line level, asynchronous.
REQ-013 ps2CkO  out  1  1 pulls the PS/2 clock line low; 0 releases it (open drain).
REQ-014 ps2DQO  out  1  1 pulls the PS/2 data line low; 0 releases it (open drain).

Function
REQ-015 ps2CkI and ps2DQI shall each pass through a 2-FF synchronizer; the clock line shall also pass through the FILTER-sample glitch filter. A falling edge is a filtered 1->0 transition.
REQ-016 The state machine shall have the states IDLE, INHIBIT, SEND, ACK, RELEASE and FINISH.
REQ-017 IDLE: on start=1, latch data, compute odd parity p = ~^data, clear the bit counter, go to INHIBIT; busy=1 on the next cycle.
REQ-018 INHIBIT: ps2CkO=1 and ps2DQO=0 for exactly INHIBIT cycles.
REQ-019 After INHIBIT, go to SEND: ps2DQO=1 (start bit) and ps2CkO=0 in the same cycle; restart the timeout counter.
REQ-020 SEND, falling edges 1 to 8: ps2DQO <= ~data[n-1], LSB first.
REQ-021 SEND, falling edge 9: ps2DQO <= ~p.
REQ-022 SEND, falling edge 10: ps2DQO <= 0 (stop bit), then go to ACK.
REQ-023 ACK: on the next falling edge, sample synchronized data; 0 is ACK, 1 sets the internal nack flag. Go to RELEASE.
REQ-024 RELEASE: wait until the synchronized data and filtered clock are both 1, then go to FINISH.
REQ-025 FINISH: done=1 for one cycle, error=nack, then go to IDLE; busy=0 from the following cycle.
REQ-026 The timeout counter shall reset on every falling edge and shall run in SEND, ACK and RELEASE.
REQ-027 When the timeout counter reaches TIMEOUT, both lines shall be released immediately and the block shall go to FINISH with error=1.
REQ-028 start while busy=1, or in the FINISH cycle, shall be ignored and shall have no other effect.
REQ-029 Falling edges in IDLE shall be ignored; device-to-host traffic shall not disturb the block.
REQ-030 ps2CkO and ps2DQO shall be registered outputs with no combinational path from any input.
REQ-031 done and error shall be 0 outside FINISH.

Reset
REQ-032 When reset is high, the block shall asynchronously enter IDLE with ps2CkO=0, ps2DQO=0, busy=0, done=0, error=0, and all counters and flags cleared.
REQ-033 Reset asserted mid-transfer shall release both lines immediately, shall produce no done pulse, and the block shall accept a new start on the first cycle after reset deasserts.

Verification
REQ-034 Use INHIBIT=32 and TIMEOUT=2000. Send data=8'hED with a device model giving ACK. Required: ps2CkO high for exactly 32 cycles; then bits 1,0,1,1,0,1,1,1, parity 1, stop 1 on the line; done=1 with error=0.
REQ-035 Send data=8'hF4, where the device model leaves data high at the ACK edge. Required: parity bit 0; done=1 with error=1.
REQ-036 Send data=8'h00 and the device never clocks. Required: done=1 with error=1 exactly 2000 cycles after inhibit ends; both lines released.
REQ-037 Pulse start three cycles after an accepted start, carrying 8'hFF. Required: ignored; the transferred byte is still the first one, and only one done pulse occurs.
REQ-038 Assert reset after falling edge 5. Required: ps2CkO=0, ps2DQO=0, busy=0 immediately; no done pulse; a new start is accepted after reset deasserts.
REQ-039 Inject 3-cycle clock glitches during SEND with FILTER=8. Required: no extra bits shifted; the transfer completes correctly.
